inst_fetch: RTL

Instruction fetch stage for the RV32I core. It sits directly upstream of the control decode logic.
- Holds the fetch PC and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned words with their PC in a small FIFO and presents them to decode as Instruction / Instr_PC / Instr_Valid.
- Handles redirects from branch/jump resolution (PC_Sel, Branch_Target) by flushing buffered and in-flight fetches.

---
 rtl/inst_fetch.sv | 90 +++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage with credit-limited imem requests, fetch buffer and redirect flush
// Ports: Clk/Rst (async active-high); Imem_Req_* request channel out; Imem_Rsp_* in-order
// response words in; PC_Sel/Branch_Target redirect; Stall holds the head entry;
// Instruction/Instr_PC/Instr_Valid present the buffer head to decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        Imem_Req_Valid,
  input  logic        Imem_Req_Ready,
  output logic [31:0] Imem_Req_Addr,
  input  logic        Imem_Rsp_Valid,
  input  logic [31:0] Imem_Rsp_Data,
  input  logic        PC_Sel,
  input  logic [31:0] Branch_Target,
  input  logic        Stall,
  output logic [31:0] Instruction,
  output logic [31:0] Instr_PC,
  output logic        Instr_Valid
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  typedef enum logic {FETCH, FLUSH} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, last_pc;
  logic [CW-1:0] outstanding, out_nx, drop, drop_nx, fifo_count;
  logic [CW:0] used;
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [31:0] fifo_pc [FIFO_DEPTH];
  logic [31:0] pcq [FIFO_DEPTH];
  logic [PW-1:0] head, tail, pcq_head, pcq_tail;
  logic accept, rsp, push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign Imem_Req_Addr = fetch_pc;
  assign Instr_Valid   = fifo_count != '0;
  assign Instruction   = Instr_Valid ? fifo_data[head] : NOP_INSTR;
  assign Instr_PC      = Instr_Valid ? fifo_pc[head] : last_pc;
  always_comb begin
    used           = {1'b0, outstanding} + {1'b0, fifo_count};
    // Credit counts both in-flight and buffered words so a response always has a slot.
    Imem_Req_Valid = !Rst && (state == FETCH) && (used < DEPTH_C);
    accept         = Imem_Req_Valid && Imem_Req_Ready;
    rsp            = Imem_Rsp_Valid && (outstanding != '0);
    push           = rsp && (state == FETCH) && !PC_Sel;
    pop            = Instr_Valid && !Stall && !PC_Sel;
    out_nx         = outstanding + CW'(accept) - CW'(rsp);
    // Every request still in flight after a redirect belongs to the old path.
    drop_nx        = PC_Sel ? out_nx : (state == FLUSH && rsp) ? drop - CW'(1) : drop;
    state_nx       = PC_Sel ? ((out_nx != '0) ? FLUSH : FETCH)
                   : (state == FLUSH && drop_nx == '0) ? FETCH : state;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      head        <= '0;
      tail        <= '0;
      pcq_head    <= '0;
      pcq_tail    <= '0;
      last_pc     <= '0;
    end else begin
      state       <= state_nx;
      outstanding <= out_nx;
      drop        <= drop_nx;
      fetch_pc    <= PC_Sel ? (Branch_Target & 32'hFFFF_FFFC) : accept ? fetch_pc + 32'd4 : fetch_pc;
      pcq_tail    <= accept ? inc(pcq_tail) : pcq_tail;
      pcq_head    <= rsp ? inc(pcq_head) : pcq_head;
      last_pc     <= Instr_PC;
      fifo_count  <= PC_Sel ? '0 : fifo_count + CW'(push) - CW'(pop);
      head        <= PC_Sel ? '0 : pop ? inc(head) : head;
      tail        <= PC_Sel ? '0 : push ? inc(tail) : tail;
    end
  end
  always_ff @(posedge Clk) begin
    if (accept) pcq[pcq_tail] <= fetch_pc;
    if (push) begin
      fifo_data[tail] <= Imem_Rsp_Data;
      fifo_pc[tail]   <= pcq[pcq_head];
    end
  end
endmodule
